// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adder_rr_arbiter                                              |
// | Desc     : round-robin sharing of one ripple-carry adder among R clients |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module adder_rr_arbiter #(
    parameter int N   = 4,
    parameter int R   = 4,
    parameter int IDW = (R > 2) ? $clog2(R) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [IDW-1:0] resp_id,
    output logic [N-1:0]   resp_sum,
    output logic           resp_cout
);

    localparam logic [1:0]   S_IDLE    = 2'd0;
    localparam logic [1:0]   S_COMPUTE = 2'd1;
    localparam logic [1:0]   S_RESPOND = 2'd2;
    localparam logic [IDW:0] C_R       = (IDW+1)'(R);

    logic [1:0]     r_state;
    logic [1:0]     w_state_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] w_grant_idx;
    logic [IDW-1:0] w_ptr_next;
    logic [IDW:0]   w_inc;
    logic           w_grant_any;
    logic           w_accept;
    logic [N-1:0]   r_op_a;
    logic [N-1:0]   r_op_b;
    logic [N-1:0]   w_add_sum;
    logic           w_add_cout;
    logic           r_resp_valid;
    logic [IDW-1:0] r_resp_id;
    logic [N-1:0]   r_resp_sum;
    logic           r_resp_cout;
    logic [IDW-1:0] w_cand [R];

    // w_cand[k] is the requester checked k-th, counting from r_rr_ptr modulo R
    for (genvar k = 0; k < R; k++) begin : g_cand
        localparam logic [IDW:0] C_K = (IDW+1)'(k);
        logic [IDW:0] w_wrap;
        assign w_wrap     = {1'b0, r_rr_ptr} + C_K;
        assign w_cand[k]  = (w_wrap >= C_R) ? IDW'(w_wrap - C_R) : w_wrap[IDW-1:0];
    end

    // Scanning from the far end lets the nearest valid candidate win
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand[k];
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_grant_any;
    assign w_inc      = {1'b0, w_grant_idx} + (IDW+1)'(1);
    assign w_ptr_next = (w_inc == C_R) ? '0 : w_inc[IDW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_grant_any) w_state_next = S_COMPUTE;
            S_COMPUTE: w_state_next = S_RESPOND;
            S_RESPOND: if (resp_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((r_state == S_IDLE) && w_grant_any && !rst) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= '0;
            r_resp_cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a   <= req_a[int'(w_grant_idx)*N +: N];
                r_op_b   <= req_b[int'(w_grant_idx)*N +: N];
                r_id     <= w_grant_idx;
                r_rr_ptr <= w_ptr_next;
            end
            if (r_state == S_COMPUTE) begin
                r_resp_sum   <= w_add_sum;
                r_resp_cout  <= w_add_cout;
                r_resp_id    <= r_id;
                r_resp_valid <= 1'b1;
            end
            if ((r_state == S_RESPOND) && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    RippleCarryAdder_nBit #(.N(N)) u_adder (
        .a    (r_op_a),
        .b    (r_op_b),
        .cin  (1'b0),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;
    assign resp_cout  = r_resp_cout;

endmodule

module RippleCarryAdder_nBit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[N];

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adder_rr_arbiter                                           |
// | Desc     : self-checking bench for the shared-adder round-robin arbiter  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module tb_adder_rr_arbiter;

    localparam int N   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;

    typedef struct {
        int id;
        int a;
        int b;
        int sum;
        int cout;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [N-1:0]   resp_sum;
    logic           resp_cout;

    adder_rr_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[6];
    int   acc_t[$];
    int   rid[$];
    int   rsum[$];

    // Transaction-level reference: pointer, one outstanding job, its age in edges
    int   m_ptr;
    bit   m_busy;
    int   m_age;
    int   m_id;
    int   m_full;
    bit   pend[R];
    int   ra[R];
    int   rb[R];
    int   g;
    int   exp_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]     = 1'b1;
        req_a[i*N +: N]  = N'(a);
        req_b[i*N +: N]  = N'(b);
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int i, input string name);
        int n = 0;
        settle();
        while (!req_ready[i] && n < 20) begin
            tick();
            settle();
            n++;
        end
        check({name, "_grant"}, 32'(req_ready[i]), 1);
    endtask

    task automatic wait_resp(input int id, input int sum, input int cout, input string name);
        int n = 0;
        settle();
        while (!resp_valid && n < 10) begin
            tick();
            settle();
            n++;
        end
        check({name, "_valid"}, 32'(resp_valid), 1);
        check({name, "_id"},    32'(resp_id),    id);
        check({name, "_sum"},   32'(resp_sum),   sum);
        check({name, "_cout"},  32'(resp_cout),  cout);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        set_req(v.id, v.a, v.b);
        wait_ready(v.id, name);
        tick();
        clr_req(v.id);
        wait_resp(v.id, v.sum, v.cout, name);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{id: 2, a: 9,  b: 8,  sum: 1,  cout: 1};
        vecs[1] = '{id: 0, a: 15, b: 15, sum: 14, cout: 1};
        vecs[2] = '{id: 1, a: 0,  b: 0,  sum: 0,  cout: 0};
        vecs[3] = '{id: 3, a: 15, b: 1,  sum: 0,  cout: 1};
        vecs[4] = '{id: 2, a: 8,  b: 7,  sum: 15, cout: 0};
        vecs[5] = '{id: 0, a: 6,  b: 3,  sum: 9,  cout: 0};

        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        rst        = 1'b1;
        req_valid  = 4'b0001;
        tick();
        settle();
        check("reset_ready", 32'(req_ready), 0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        settle();
        check("reset_valid", 32'(resp_valid), 0);
        check("reset_id",    32'(resp_id),    0);
        check("reset_sum",   32'(resp_sum),   0);
        check("reset_cout",  32'(resp_cout),  0);

        // Single request from requester 2, exact cycle timing
        resp_ready = 1'b1;
        set_req(2, 9, 8);
        settle();
        check("single_ready", 32'(req_ready), 4'b0100);
        tick();
        clr_req(2);
        settle();
        check("single_ready_compute", 32'(req_ready), 0);
        check("single_valid_compute", 32'(resp_valid), 0);
        tick();
        settle();
        check("single_valid", 32'(resp_valid), 1);
        check("single_id",    32'(resp_id),    2);
        check("single_sum",   32'(resp_sum),   1);
        check("single_cout",  32'(resp_cout),  1);
        tick();
        settle();
        check("single_valid_after", 32'(resp_valid), 0);
        tick();

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // All requesters continuously valid
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, 2*i + 1, 2*i + 2);
        for (int c = 0; c < 40 && rid.size() < 5; c++) begin
            settle();
            if (req_ready != '0) acc_t.push_back(c);
            if (resp_valid) begin
                rid.push_back(int'(resp_id));
                rsum.push_back(int'(resp_sum));
            end
            tick();
        end
        req_valid = '0;
        check("stream_count", 32'(rid.size()), 5);
        check("stream_accepts", 32'(acc_t.size()), 5);
        for (int k = 0; k < rid.size(); k++) begin
            check($sformatf("stream_id%0d", k),  32'(rid[k]),  k % R);
            check($sformatf("stream_sum%0d", k), 32'(rsum[k]), 4*(k % R) + 3);
        end
        for (int k = 1; k < acc_t.size(); k++)
            check($sformatf("stream_gap%0d", k), 32'(acc_t[k] - acc_t[k-1]), 3);

        // Backpressure with another requester waiting
        resp_ready = 1'b0;
        set_req(0, 15, 15);
        wait_ready(0, "bp");
        tick();
        clr_req(0);
        set_req(1, 1, 1);
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            check("bp_valid", 32'(resp_valid), 1);
            check("bp_sum",   32'(resp_sum),   14);
            check("bp_cout",  32'(resp_cout),  1);
            check("bp_id",    32'(resp_id),    0);
            check("bp_ready", 32'(req_ready),  0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        settle();
        check("bp_released", 32'(resp_valid), 0);
        check("bp_next_grant", 32'(req_ready), 4'b0010);
        tick();
        clr_req(1);
        wait_resp(1, 2, 0, "bp_next");
        tick();

        // Fairness: pointer wraps to 0 after serving requester 3
        do_reset();
        resp_ready = 1'b1;
        set_req(3, 2, 3);
        wait_ready(3, "fair3");
        check("fair3_onehot", 32'(req_ready), 4'b1000);
        tick();
        clr_req(3);
        wait_resp(3, 5, 0, "fair3");
        tick();
        set_req(0, 4, 4);
        set_req(3, 6, 1);
        settle();
        check("fair_first", 32'(req_ready), 4'b0001);
        tick();
        clr_req(0);
        wait_resp(0, 8, 0, "fair0");
        tick();
        settle();
        check("fair_second", 32'(req_ready), 4'b1000);
        tick();
        clr_req(3);
        wait_resp(3, 7, 0, "fair3b");
        tick();

        // Reset while computing discards the job and the pointer advance
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 5, 5);
        wait_ready(0, "rstc");
        tick();
        clr_req(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rstc_valid", 32'(resp_valid), 0);
        check("rstc_id",    32'(resp_id),    0);
        check("rstc_sum",   32'(resp_sum),   0);
        check("rstc_cout",  32'(resp_cout),  0);
        tick();
        settle();
        check("rstc_no_resp", 32'(resp_valid), 0);
        set_req(0, 3, 3);
        set_req(2, 1, 2);
        settle();
        check("rstc_ptr0", 32'(req_ready), 4'b0001);
        tick();
        clr_req(0);
        wait_resp(0, 6, 0, "rstc_next");
        tick();
        wait_ready(2, "rstc2");
        tick();
        clr_req(2);
        wait_resp(2, 3, 0, "rstc2");
        tick();

        // Randomized traffic against the transaction-level reference
        do_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_age  = 0;
        for (int i = 0; i < R; i++) pend[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < R; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i]   = $urandom_range(0, 15);
                    rb[i]   = $urandom_range(0, 15);
                    set_req(i, ra[i], rb[i]);
                end
            end
            settle();
            g = -1;
            if (!m_busy)
                for (int k = R - 1; k >= 0; k--)
                    if (pend[(m_ptr + k) % R]) g = (m_ptr + k) % R;
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            check("rnd_ready", 32'(req_ready), exp_rdy);
            check("rnd_valid", 32'(resp_valid), (m_busy && m_age >= 1) ? 1 : 0);
            if (m_busy && m_age >= 1) begin
                check("rnd_id",   32'(resp_id),   m_id);
                check("rnd_sum",  32'(resp_sum),  m_full % 16);
                check("rnd_cout", 32'(resp_cout), m_full / 16);
            end
            if (m_busy) begin
                if (m_age >= 1 && resp_ready) m_busy = 1'b0;
                else                          m_age  = 1;
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = g;
                m_full = ra[g] + rb[g];
                m_ptr  = (g + 1) % R;
            end
            tick();
            if (g >= 0) begin
                pend[g] = 1'b0;
                clr_req(g);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
